// File: rtl/softmax_row_sched_pkg.sv
// Shared constants and state encoding for the softmax row scheduler.
package softmax_row_sched_pkg;

  // Default geometry used across the attention modules (Q8.8 elements).
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_COL        = 8;
  localparam int DEF_ROW        = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } sched_state_t;

endpackage

// File: rtl/softmax_row_sched_buf.sv
// Row buffer: DEPTH x WIDTH register file, one write port, one async read port.
module softmax_row_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; every entry is rewritten before use.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Each entry captures write data when addressed.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_addr == AW'(gi))) begin
        mem_q[gi] <= wr_data;
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/softmax_row_sched.sv
// Buffers a score matrix row by row, runs each row through the shared
// softmax datapath in place, then streams the normalized rows out.
module softmax_row_sched
  import softmax_row_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COL        = DEF_COL,
  parameter int ROW        = DEF_ROW,
  parameter int ROW_CNT_W  = $clog2(ROW)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COL*DATA_WIDTH-1:0] in_row,
  output logic                      sm_start,
  output logic [COL*DATA_WIDTH-1:0] sm_in,
  input  logic                      sm_done,
  input  logic [COL*DATA_WIDTH-1:0] sm_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COL*DATA_WIDTH-1:0] out_row,
  output logic                      out_last
);

  localparam int W = COL * DATA_WIDTH;

  sched_state_t         state_q, state_d;
  logic [ROW_CNT_W-1:0] r_q, r_d;
  logic                 r_last;
  logic                 wr_en;
  logic [W-1:0]         wr_data;
  logic [W-1:0]         rd_data;

  assign r_last = (r_q == ROW_CNT_W'(ROW - 1));

  // Single buffer serves load, in-place result write-back and drain; r addresses it.
  softmax_row_buf #(
    .DEPTH (ROW),
    .WIDTH (W),
    .AW    (ROW_CNT_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (r_q),
    .wr_data (wr_data),
    .rd_addr (r_q),
    .rd_data (rd_data)
  );

  // State and row counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  // Next state, counter update, buffer write control and all outputs.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    in_ready  = 1'b0;
    sm_start  = 1'b0;
    sm_in     = '0;
    out_valid = 1'b0;
    out_row   = '0;
    out_last  = 1'b0;
    wr_en     = 1'b0;
    wr_data   = in_row;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          r_d     = '0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (r_last) begin
            state_d = S_ISSUE;
            r_d     = '0;
          end else begin
            r_d = r_q + ROW_CNT_W'(1);
          end
        end
      end
      S_ISSUE: begin
        // sm_done is not looked at here, so a zero-latency response is dropped.
        sm_start = 1'b1;
        sm_in    = rd_data;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        sm_in = rd_data;
        if (sm_done) begin
          wr_en   = 1'b1;
          wr_data = sm_out;
          if (r_last) begin
            state_d = S_DRAIN;
            r_d     = '0;
          end else begin
            state_d = S_ISSUE;
            r_d     = r_q + ROW_CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_row   = rd_data;
        out_last  = r_last;
        if (out_ready) begin
          if (r_last) begin
            done    = 1'b1;
            state_d = S_IDLE;
            r_d     = '0;
          end else begin
            r_d = r_q + ROW_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        r_d     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_softmax_row_sched.sv
// Self-checking bench for softmax_row_sched with a behavioural datapath stub.
module tb_softmax_row_sched;

  localparam int DW  = 16;
  localparam int COL = 8;
  localparam int ROW = 8;
  localparam int W   = DW * COL;

  typedef struct {
    string name;
    int    lat;
    bit    hold;
    bit    bp;
    int    gap_at;
    int    gap_len;
    bit    glitch;
    bit    spur;
    int    base;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_drv = 1'b0;
  logic         start_glitch = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_row = '0;
  logic         out_ready = 1'b1;
  logic         force_done = 1'b0;
  logic         busy, done, in_ready, sm_start, out_valid, out_last;
  logic [W-1:0] sm_in, out_row, sm_out;
  logic         sm_done, stub_done;
  logic [7:0]   pipe;

  int  lat = 3;
  bit  hold = 1'b0, bp = 1'b0, glitch_en = 1'b0, spur_en = 1'b0;
  bit  glitched = 1'b0, spurred = 1'b0;
  int  cyc = 0, vec_cnt = 0, err_cnt = 0;
  int  starts_n = 0, prev_start = 0, first_start = -1, hs_n = 0;
  int  drain_cyc = 0, first_valid = -1, done_n = 0, last_hs = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] first_out = '0, prev_row = '0;
  logic         prev_valid = 1'b0, prev_ready = 1'b0;
  vec_t         vecs[5];

  softmax_row_sched #(
    .DATA_WIDTH (DW),
    .COL        (COL),
    .ROW        (ROW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start_drv | start_glitch),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .sm_start  (sm_start),
    .sm_in     (sm_in),
    .sm_done   (sm_done),
    .sm_out    (sm_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last)
  );

  initial forever #5 clk = ~clk;

  // Datapath stub: result is the inverted input, done arrives lat cycles after sm_start.
  always @(posedge clk or posedge rst) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[6:0], sm_start};
  end

  always_comb begin
    stub_done = 1'b0;
    if (hold) stub_done = |pipe[lat-1 +: 4];
    else      stub_done = pipe[lat-1];
  end

  assign sm_done = stub_done | force_done;
  assign sm_out  = ~sm_in;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] make_row(input int r, input int base);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < COL; c++) v[c*DW +: DW] = DW'(base + r + 1);
    return v;
  endfunction

  // Observation at the falling edge: scoreboard pops, stall/timing checks.
  task automatic sample();
    logic [W-1:0] e;
    if (rst) return;
    if (sm_start) begin
      if (starts_n == 0) first_start = cyc;
      else if (!hold) chk("start_spacing", W'(cyc - prev_start), W'(lat + 1));
      prev_start = cyc;
      starts_n++;
    end
    if (out_valid) begin
      drain_cyc++;
      if (first_valid < 0) first_valid = cyc;
      if (prev_valid && !prev_ready) chk("stall_hold", out_row, prev_row);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", W'(1), W'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_row", out_row, e);
        end
        chk("out_last", W'(out_last), W'(hs_n == ROW - 1));
        $display("row %0d out=%h last=%b cyc=%0d", hs_n, out_row, out_last, cyc);
        if (hs_n == 0) first_out = out_row;
        hs_n++;
      end
    end
    if (done) done_n++;
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_row   = out_row;
  endtask

  // Inputs that follow the DUT: out_ready pattern and injected disturbances.
  task automatic background_drive();
    force_done   = 1'b0;
    start_glitch = 1'b0;
    if (!bp || !out_valid) out_ready = 1'b1;
    else                   out_ready = ~out_ready;
    if (glitch_en && !glitched && starts_n == 3 && busy && !sm_start) begin
      start_glitch = 1'b1;
      glitched     = 1'b1;
    end
    if (spur_en && !spurred && out_valid) begin
      force_done = 1'b1;
      spurred    = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    background_drive();
  endtask

  task automatic drive_row(input int r, input int base);
    int n;
    in_row   = make_row(r, base);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk("in_ready_timeout", W'(in_ready), W'(1));
    exp_q.push_back(~in_row);
    last_hs = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clear_run();
    starts_n = 0; hs_n = 0; drain_cyc = 0; first_valid = -1; first_start = -1;
    done_n = 0; glitched = 1'b0; spurred = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_matrix(input vec_t v);
    int n;
    lat = v.lat; hold = v.hold; bp = v.bp; glitch_en = v.glitch; spur_en = v.spur;
    clear_run();
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    chk("start_accepted", W'(in_ready), W'(1));
    for (int r = 0; r < ROW; r++) begin
      if (r == v.gap_at) begin
        for (int g = 0; g < v.gap_len; g++) tick();
      end
      drive_row(r, v.base);
    end
    n = 0;
    while (done_n == 0 && n < 2000) begin tick(); n++; end
    chk("done_pulses", W'(done_n), W'(1));
    chk("sm_start_count", W'(starts_n), W'(ROW));
    chk("out_handshakes", W'(hs_n), W'(ROW));
    chk("rows_left", W'(exp_q.size()), W'(0));
    chk("drain_cycles", W'(drain_cyc), W'(v.bp ? 2 * ROW : ROW));
    chk("idle_after_done", W'(busy), W'(0));
    if (!v.hold) begin
      chk("first_sm_start", W'(first_start - last_hs), W'(1));
      chk("first_out_valid", W'(first_valid - last_hs), W'(ROW * (v.lat + 1) + 1));
    end
    if (v.base == 0) chk("row0_elem0", W'(first_out[15:0]), W'(16'hFFFE));
    $display("run %s: starts=%0d rows=%0d drain=%0d", v.name, starts_n, hs_n, drain_cyc);
  endtask

  initial begin
    int n;
    vecs[0] = '{"nominal",      3, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 0};
    vecs[1] = '{"backpressure", 3, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, 16};
    vecs[2] = '{"gaps_ignored", 3, 1'b0, 1'b1,  4, 5, 1'b1, 1'b1, 32};
    vecs[3] = '{"lat1",         1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 48};
    vecs[4] = '{"done_held",    3, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, 64};

    tick();
    tick();
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_sm_start", W'(sm_start), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_last", W'(out_last), W'(0));
    chk("rst_sm_in", sm_in, W'(0));
    rst = 1'b0;

    // in_valid in IDLE must not start anything.
    in_valid = 1'b1;
    tick();
    tick();
    chk("idle_in_ready", W'(in_ready), W'(0));
    chk("idle_busy", W'(busy), W'(0));
    in_valid = 1'b0;
    tick();

    // Consecutive runs: each start lands in the cycle after the previous done.
    for (int i = 0; i < 5; i++) run_matrix(vecs[i]);

    // Asynchronous reset during WAIT of row 5.
    lat = 3; hold = 1'b0; bp = 1'b0; glitch_en = 1'b0; spur_en = 1'b0;
    clear_run();
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    for (int r = 0; r < ROW; r++) drive_row(r, 96);
    n = 0;
    while (starts_n < 6 && n < 500) begin tick(); n++; end
    chk("reach_row5", W'(starts_n), W'(6));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_sm_start", W'(sm_start), W'(0));
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_in_ready", W'(in_ready), W'(0));
    chk("arst_sm_in", sm_in, W'(0));
    $display("async reset applied during row 5 wait");
    tick();
    tick();
    rst = 1'b0;
    tick();

    vecs[0].name = "after_reset";
    vecs[0].base = 0;
    run_matrix(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/softmax_row_sched.md
Name: softmax_row_sched

Overview:
- Sequencing controller that wraps a row-wise softmax datapath (MatSoftmax-style, Q8.8 fixed point) for the attention pipeline.
- Accepts one score matrix as a stream of rows and buffers it locally.
- Issues each row to the shared softmax datapath through a start/done handshake and writes the result back in place.
- Streams the normalized rows out with backpressure and a last-row marker.

Parameters:
- DATA_WIDTH, 16, width of one element (Q8.8).
- COL, 8, elements per row.
- ROW, 8, rows per matrix; minimum 2.
- ROW_CNT_W, $clog2(ROW), width of the row index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a matrix; honoured only in IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last output row handshakes.
- in_valid  in  1  input row valid.
- in_ready  out  1  high only in LOAD.
- in_row  in  COL*DATA_WIDTH  input row; element 0 in the LSBs.
- sm_start  out  1  one-cycle pulse that launches the datapath on sm_in.
- sm_in  out  COL*DATA_WIDTH  row presented to the datapath.
- sm_done  in  1  datapath result valid; sampled only in WAIT.
- sm_out  in  COL*DATA_WIDTH  datapath result.
- out_valid  out  1  output row valid.
- out_ready  in  1  downstream accept.
- out_row  out  COL*DATA_WIDTH  normalized row.
- out_last  out  1  high with out_valid when the row index is ROW-1.

Behaviour:
- Storage is an internal buffer of ROW entries, each COL*DATA_WIDTH wide, plus a row counter r (ROW_CNT_W bits).
- Reset, asserted at any time including mid-matrix:
  - state=IDLE, r=0.
  - busy, done, in_ready, sm_start, out_valid and out_last are all 0.
  - sm_in is 0.
  - Buffer contents are not reset and are don't-care.
- States:
  - IDLE:
    - start=1 -> LOAD, r=0.
    - in_valid is ignored.
  - LOAD:
    - in_ready=1.
    - On in_valid: buf[r]<=in_row and r increments.
    - On the handshake with r=ROW-1 -> ISSUE, r=0.
  - ISSUE:
    - Lasts one cycle: sm_start=1, sm_in=buf[r].
    - Always -> WAIT.
  - WAIT:
    - sm_in stays equal to buf[r].
    - On sm_done: buf[r]<=sm_out.
    - If r=ROW-1 -> DRAIN with r=0; otherwise r increments and -> ISSUE.
  - DRAIN:
    - out_valid=1, out_row=buf[r], out_last=(r==ROW-1).
    - On out_ready with r<ROW-1: r increments.
    - On out_ready with r=ROW-1: done=1 for one cycle and -> IDLE.
- sm_in is 0 outside ISSUE and WAIT.
- out_row holds stable while out_valid=1 and out_ready=0.
- Ignored events:
  - start while busy.
  - sm_done outside WAIT, including an sm_done coincident with sm_start in ISSUE.
- Datapath latency is therefore at least 1 cycle after sm_start.
- Throughput:
  - Each row takes 1 cycle of ISSUE plus the datapath latency L, counted in cycles from sm_start to sm_done.
  - The next sm_start follows sm_done by exactly 1 cycle.
- Latency, with the last input handshake at cycle T:
  - First sm_start at T+1.
  - first out_valid = T + ROW*(L+1) + 1.
- Output handshake is combinational on out_ready, with no bubbles: one row per cycle when out_ready is held high.
- done and the IDLE transition happen in the same cycle; a start in the following cycle is accepted.
- Arithmetic: none; the block only moves data, so widths pass through unchanged.

Decomposition:
- Shared package/header holds:
  - state encodings S_IDLE=0, S_LOAD=1, S_ISSUE=2, S_WAIT=3, S_DRAIN=4 (3 bits);
  - the default DATA_WIDTH/COL/ROW constants used across the attention modules.
- One natural sub-module, softmax_row_buf: ROW x (COL*DATA_WIDTH) register file.
  - One write port (address, data, enable).
  - One asynchronous read port.
  - The controller muxes the write data between in_row and sm_out.
- The FSM and counter stay in softmax_row_sched.

Test Plan:
- Bench datapath stub: sm_out = ~sm_in, sm_done pulsed 3 cycles after sm_start (L=3).
- Nominal: ROW=COL=8.
  - Stimulus: start, then 8 back-to-back rows with in_row[r] all elements = r+1.
  - Expected: first sm_start 1 cycle after the last handshake; 8 sm_start pulses spaced 4 cycles apart.
  - Expected: out_valid at T+33; out_row[r] elements = ~(r+1) (row 0 = 0xFFFE).
  - Expected: out_last only on row 7; done pulses once.
- Backpressure:
  - Stimulus: toggle out_ready 1/0 every cycle in DRAIN.
  - Expected: out_row stable while stalled; exactly 8 handshakes in 16 cycles; done after the 8th.
- Input gaps / ignored inputs:
  - Stimulus: in_valid deasserted for 5 cycles between rows 3 and 4 → still exactly 8 rows stored in order.
  - Stimulus: start pulsed during WAIT → no effect.
  - Stimulus: spurious sm_done in DRAIN → buffer unchanged.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously (between clk edges) during WAIT of row 5.
  - Expected: busy, sm_start, out_valid and in_ready go to 0 immediately.
  - Expected: a new start after reset is accepted and the full sequence completes correctly.
- Datapath-latency corners:
  - L=1 → rows spaced 2 cycles apart.
  - sm_done held high for 4 cycles → only one capture per row.
  - Back-to-back matrices: start in the cycle after done → second matrix processed with no lost rows.
